// File: rtl/rename_map_pkg.sv
// Shared ROB state encodings and rename-group constants for the rename stage.
package rename_map_pkg;

    typedef enum logic [1:0] {
        ROB_STATE_IDLE     = 2'd0,
        ROB_STATE_ROLLBACK = 2'd1,
        ROB_STATE_WALK     = 2'd2
    } rob_state_e;

    localparam int WALK_SIZE    = 2;
    localparam int RENAME_WIDTH = 2;

endpackage

// File: rtl/rat_regfile.sv
// Register alias table: combinational read ports, ordered write ports
// (the highest port wins on an equal address), and a whole-table bulk load.
module rat_regfile #(
    parameter int ARCH_REGS      = 32,
    parameter int LOG_ARCH_REGS  = 5,
    parameter int PREG_IDX_WIDTH = 6,
    parameter int RD_PORTS       = 4,
    parameter int OLD_PORTS      = 2,
    parameter int WR_PORTS       = 2
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [RD_PORTS-1:0][LOG_ARCH_REGS-1:0]      rd_addr,
    output logic [RD_PORTS-1:0][PREG_IDX_WIDTH-1:0]     rd_data,
    input  logic [OLD_PORTS-1:0][LOG_ARCH_REGS-1:0]     old_addr,
    output logic [OLD_PORTS-1:0][PREG_IDX_WIDTH-1:0]    old_data,
    input  logic [WR_PORTS-1:0]                         wr_en,
    input  logic [WR_PORTS-1:0][LOG_ARCH_REGS-1:0]      wr_addr,
    input  logic [WR_PORTS-1:0][PREG_IDX_WIDTH-1:0]     wr_data,
    input  logic                                        bulk_en,
    input  logic [ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0]    bulk_data,
    output logic [ARCH_REGS-1:0][PREG_IDX_WIDTH-1:0]    map_q
);

    for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
        assign rd_data[r] = map_q[rd_addr[r]];
    end

    for (genvar o = 0; o < OLD_PORTS; o++) begin : g_old
        assign old_data[o] = map_q[old_addr[o]];
    end

    // Arch reg 0 is hard-wired to preg 0, so writes to it are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++)
                map_q[i] <= PREG_IDX_WIDTH'(i);
        end else if (bulk_en) begin
            map_q <= bulk_data;
        end else begin
            for (int w = 0; w < WR_PORTS; w++)
                if (wr_en[w] && wr_addr[w] != '0)
                    map_q[wr_addr[w]] <= wr_data[w];
        end
    end

endmodule

// File: rtl/rename_map.sv
// Two-wide rename stage: speculative and architectural alias tables with
// freelist handshake, registered rename results, commit and rollback/walk.
module rename_map
    import rename_map_pkg::*;
#(
    parameter int ARCH_REGS      = 32,
    parameter int LOG_ARCH_REGS  = 5,
    parameter int PREG_IDX_WIDTH = 6
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        instr0_valid,
    input  logic [LOG_ARCH_REGS-1:0]    instr0_lrs1,
    input  logic [LOG_ARCH_REGS-1:0]    instr0_lrs2,
    input  logic [LOG_ARCH_REGS-1:0]    instr0_lrd,
    input  logic                        instr0_need_to_wb,
    input  logic                        instr1_valid,
    input  logic [LOG_ARCH_REGS-1:0]    instr1_lrs1,
    input  logic [LOG_ARCH_REGS-1:0]    instr1_lrs2,
    input  logic [LOG_ARCH_REGS-1:0]    instr1_lrd,
    input  logic                        instr1_need_to_wb,
    output logic                        in_ready,
    input  logic [LOG_ARCH_REGS:0]      free_count,
    output logic                        req0_valid,
    output logic                        req1_valid,
    input  logic [PREG_IDX_WIDTH-1:0]   req0_data,
    input  logic [PREG_IDX_WIDTH-1:0]   req1_data,
    output logic                        out0_valid,
    output logic [PREG_IDX_WIDTH-1:0]   out0_prs1,
    output logic [PREG_IDX_WIDTH-1:0]   out0_prs2,
    output logic [PREG_IDX_WIDTH-1:0]   out0_prd,
    output logic [PREG_IDX_WIDTH-1:0]   out0_old_prd,
    output logic                        out1_valid,
    output logic [PREG_IDX_WIDTH-1:0]   out1_prs1,
    output logic [PREG_IDX_WIDTH-1:0]   out1_prs2,
    output logic [PREG_IDX_WIDTH-1:0]   out1_prd,
    output logic [PREG_IDX_WIDTH-1:0]   out1_old_prd,
    input  logic                        out_ready,
    input  logic                        commit0_valid,
    input  logic [LOG_ARCH_REGS-1:0]    commit0_lrd,
    input  logic [PREG_IDX_WIDTH-1:0]   commit0_prd,
    input  logic                        commit1_valid,
    input  logic [LOG_ARCH_REGS-1:0]    commit1_lrd,
    input  logic [PREG_IDX_WIDTH-1:0]   commit1_prd,
    input  logic [1:0]                  rob_state,
    input  logic                        rob_walk0_valid,
    input  logic [LOG_ARCH_REGS-1:0]    rob_walk0_lrd,
    input  logic [PREG_IDX_WIDTH-1:0]   rob_walk0_prd,
    input  logic                        rob_walk1_valid,
    input  logic [LOG_ARCH_REGS-1:0]    rob_walk1_lrd,
    input  logic [PREG_IDX_WIDTH-1:0]   rob_walk1_prd
);

    localparam int LW = LOG_ARCH_REGS;
    localparam int PW = PREG_IDX_WIDTH;
    localparam int CW = LOG_ARCH_REGS + 1;

    logic is_idle, is_rollback, is_walk;
    logic wb0, wb1, fire, out_valid_any;
    logic [1:0] need;

    assign is_idle     = rob_state == ROB_STATE_IDLE;
    assign is_rollback = rob_state == ROB_STATE_ROLLBACK;
    assign is_walk     = rob_state == ROB_STATE_WALK;

    assign wb0  = instr0_valid & instr0_need_to_wb & (instr0_lrd != '0);
    assign wb1  = instr1_valid & instr1_need_to_wb & (instr1_lrd != '0);
    assign need = {1'b0, wb0} + {1'b0, wb1};

    assign out_valid_any = out0_valid | out1_valid;
    assign in_ready   = is_idle & (~out_valid_any | out_ready) & (free_count >= CW'(need));
    assign fire       = in_ready & (instr0_valid | instr1_valid);
    assign req0_valid = fire & (wb0 | wb1);
    assign req1_valid = fire & wb0 & wb1;

    // Requests are compacted: a lone writer in lane 1 takes req0_data.
    logic [PW-1:0] new_prd0, new_prd1;
    assign new_prd0 = req0_data;
    assign new_prd1 = wb0 ? req1_data : req0_data;

    logic [3:0][LW-1:0] src_addr;
    logic [3:0][PW-1:0] src_prd;
    logic [1:0][LW-1:0] old_addr;
    logic [1:0][PW-1:0] old_prd;
    logic [ARCH_REGS-1:0][PW-1:0] spec_map_unused;

    assign src_addr = {instr1_lrs2, instr1_lrs1, instr0_lrs2, instr0_lrs1};
    assign old_addr = {instr1_lrd, instr0_lrd};

    logic [1:0]         spec_we;
    logic [1:0][LW-1:0] spec_waddr;
    logic [1:0][PW-1:0] spec_wdata;

    always_comb begin
        spec_we    = '0;
        spec_waddr = '0;
        spec_wdata = '0;
        if (is_walk) begin
            spec_we    = {rob_walk1_valid, rob_walk0_valid};
            spec_waddr = {rob_walk1_lrd, rob_walk0_lrd};
            spec_wdata = {rob_walk1_prd, rob_walk0_prd};
        end else if (fire) begin
            spec_we    = {wb1, wb0};
            spec_waddr = {instr1_lrd, instr0_lrd};
            spec_wdata = {new_prd1, new_prd0};
        end
    end

    // Rollback reloads from the architectural table with this cycle's commits folded in.
    logic [ARCH_REGS-1:0][PW-1:0] arch_map, arch_fwd;

    always_comb begin
        arch_fwd = arch_map;
        if (commit0_valid && commit0_lrd != '0) arch_fwd[commit0_lrd] = commit0_prd;
        if (commit1_valid && commit1_lrd != '0) arch_fwd[commit1_lrd] = commit1_prd;
    end

    rat_regfile #(
        .ARCH_REGS(ARCH_REGS), .LOG_ARCH_REGS(LW), .PREG_IDX_WIDTH(PW)
    ) u_spec (
        .clock(clock), .reset(reset),
        .rd_addr(src_addr), .rd_data(src_prd),
        .old_addr(old_addr), .old_data(old_prd),
        .wr_en(spec_we), .wr_addr(spec_waddr), .wr_data(spec_wdata),
        .bulk_en(is_rollback), .bulk_data(arch_fwd),
        .map_q(spec_map_unused)
    );

    logic [3:0][PW-1:0] arch_rd_unused;
    logic [1:0][PW-1:0] arch_old_unused;

    rat_regfile #(
        .ARCH_REGS(ARCH_REGS), .LOG_ARCH_REGS(LW), .PREG_IDX_WIDTH(PW)
    ) u_arch (
        .clock(clock), .reset(reset),
        .rd_addr('0), .rd_data(arch_rd_unused),
        .old_addr('0), .old_data(arch_old_unused),
        .wr_en({commit1_valid, commit0_valid}),
        .wr_addr({commit1_lrd, commit0_lrd}),
        .wr_data({commit1_prd, commit0_prd}),
        .bulk_en(1'b0), .bulk_data('0),
        .map_q(arch_map)
    );

    // Lane 1 sees lane 0's fresh mapping when lane 0 writes its source/dest reg.
    logic [PW-1:0] l1_prs1, l1_prs2, l1_old;
    assign l1_prs1 = (wb0 && instr0_lrd == instr1_lrs1) ? new_prd0 : src_prd[2];
    assign l1_prs2 = (wb0 && instr0_lrd == instr1_lrs2) ? new_prd0 : src_prd[3];
    assign l1_old  = (wb0 && instr0_lrd == instr1_lrd)  ? new_prd0 : old_prd[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            out0_valid   <= 1'b0;
            out0_prs1    <= '0;
            out0_prs2    <= '0;
            out0_prd     <= '0;
            out0_old_prd <= '0;
            out1_valid   <= 1'b0;
            out1_prs1    <= '0;
            out1_prs2    <= '0;
            out1_prd     <= '0;
            out1_old_prd <= '0;
        end else if (is_rollback) begin
            out0_valid <= 1'b0;
            out1_valid <= 1'b0;
        end else if (fire) begin
            out0_valid   <= instr0_valid;
            out0_prs1    <= src_prd[0];
            out0_prs2    <= src_prd[1];
            out0_prd     <= wb0 ? new_prd0 : '0;
            out0_old_prd <= wb0 ? old_prd[0] : '0;
            out1_valid   <= instr1_valid;
            out1_prs1    <= l1_prs1;
            out1_prs2    <= l1_prs2;
            out1_prd     <= wb1 ? new_prd1 : '0;
            out1_old_prd <= wb1 ? l1_old : '0;
        end else if (out_ready) begin
            out0_valid <= 1'b0;
            out1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rename_map.sv
// Directed plus randomized bench for rename_map against a sequential rename model.
module tb_rename_map;
    import rename_map_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic instr0_valid, instr0_need_to_wb, instr1_valid, instr1_need_to_wb;
    logic [4:0] instr0_lrs1, instr0_lrs2, instr0_lrd, instr1_lrs1, instr1_lrs2, instr1_lrd;
    logic in_ready;
    logic [5:0] free_count;
    logic req0_valid, req1_valid;
    logic [5:0] req0_data, req1_data;
    logic out0_valid, out1_valid;
    logic [5:0] out0_prs1, out0_prs2, out0_prd, out0_old_prd;
    logic [5:0] out1_prs1, out1_prs2, out1_prd, out1_old_prd;
    logic out_ready;
    logic commit0_valid, commit1_valid;
    logic [4:0] commit0_lrd, commit1_lrd;
    logic [5:0] commit0_prd, commit1_prd;
    logic [1:0] rob_state;
    logic rob_walk0_valid, rob_walk1_valid;
    logic [4:0] rob_walk0_lrd, rob_walk1_lrd;
    logic [5:0] rob_walk0_prd, rob_walk1_prd;

    always #5 clock = ~clock;

    rename_map dut (
        .clock(clock), .reset(reset),
        .instr0_valid(instr0_valid), .instr0_lrs1(instr0_lrs1), .instr0_lrs2(instr0_lrs2),
        .instr0_lrd(instr0_lrd), .instr0_need_to_wb(instr0_need_to_wb),
        .instr1_valid(instr1_valid), .instr1_lrs1(instr1_lrs1), .instr1_lrs2(instr1_lrs2),
        .instr1_lrd(instr1_lrd), .instr1_need_to_wb(instr1_need_to_wb),
        .in_ready(in_ready), .free_count(free_count),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .out0_valid(out0_valid), .out0_prs1(out0_prs1), .out0_prs2(out0_prs2),
        .out0_prd(out0_prd), .out0_old_prd(out0_old_prd),
        .out1_valid(out1_valid), .out1_prs1(out1_prs1), .out1_prs2(out1_prs2),
        .out1_prd(out1_prd), .out1_old_prd(out1_old_prd),
        .out_ready(out_ready),
        .commit0_valid(commit0_valid), .commit0_lrd(commit0_lrd), .commit0_prd(commit0_prd),
        .commit1_valid(commit1_valid), .commit1_lrd(commit1_lrd), .commit1_prd(commit1_prd),
        .rob_state(rob_state),
        .rob_walk0_valid(rob_walk0_valid), .rob_walk0_lrd(rob_walk0_lrd), .rob_walk0_prd(rob_walk0_prd),
        .rob_walk1_valid(rob_walk1_valid), .rob_walk1_lrd(rob_walk1_lrd), .rob_walk1_prd(rob_walk1_prd)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: plain arrays for both tables and the expected output register.
    logic [5:0] spec_m [32];
    logic [5:0] arch_m [32];
    logic       ev [2] = '{1'b0, 1'b0};
    logic [5:0] ep1 [2], ep2 [2], epd [2], eold [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0;
        instr0_valid = 0; instr0_need_to_wb = 0; instr0_lrs1 = 0; instr0_lrs2 = 0; instr0_lrd = 0;
        instr1_valid = 0; instr1_need_to_wb = 0; instr1_lrs1 = 0; instr1_lrs2 = 0; instr1_lrd = 0;
        free_count = 6'd10; req0_data = 0; req1_data = 0; out_ready = 1'b1;
        commit0_valid = 0; commit0_lrd = 0; commit0_prd = 0;
        commit1_valid = 0; commit1_lrd = 0; commit1_prd = 0;
        rob_state = ROB_STATE_IDLE;
        rob_walk0_valid = 0; rob_walk0_lrd = 0; rob_walk0_prd = 0;
        rob_walk1_valid = 0; rob_walk1_lrd = 0; rob_walk1_prd = 0;
    endtask

    // One clock: check handshake outputs, advance the model, check registered outputs.
    task automatic tick();
        logic v [2], nw [2], w [2];
        logic [4:0] s1 [2], s2 [2], d [2];
        logic [5:0] alloc [2];
        int need, idx;
        logic rdy, fire, was_reset;
        v = '{instr0_valid, instr1_valid};
        nw = '{instr0_need_to_wb, instr1_need_to_wb};
        s1 = '{instr0_lrs1, instr1_lrs1};
        s2 = '{instr0_lrs2, instr1_lrs2};
        d = '{instr0_lrd, instr1_lrd};
        alloc = '{req0_data, req1_data};
        for (int l = 0; l < 2; l++) w[l] = v[l] && nw[l] && d[l] != 5'd0;
        need = int'(w[0]) + int'(w[1]);
        rdy = (rob_state == ROB_STATE_IDLE) && (!(ev[0] || ev[1]) || out_ready)
              && (int'(free_count) >= need);
        fire = rdy && (v[0] || v[1]);
        was_reset = reset;
        #1;
        if (!was_reset) begin
            chk("in_ready", in_ready, rdy);
            chk("req0_valid", req0_valid, fire && need >= 1);
            chk("req1_valid", req1_valid, fire && need == 2);
        end
        if (was_reset) begin
            for (int i = 0; i < 32; i++) begin spec_m[i] = 6'(i); arch_m[i] = 6'(i); end
            for (int l = 0; l < 2; l++) begin
                ev[l] = 0; ep1[l] = 0; ep2[l] = 0; epd[l] = 0; eold[l] = 0;
            end
        end else begin
            if (commit0_valid && commit0_lrd != 0) arch_m[commit0_lrd] = commit0_prd;
            if (commit1_valid && commit1_lrd != 0) arch_m[commit1_lrd] = commit1_prd;
            if (rob_state == ROB_STATE_ROLLBACK) begin
                spec_m = arch_m;
                ev = '{1'b0, 1'b0};
            end else if (rob_state == ROB_STATE_WALK) begin
                if (rob_walk0_valid) spec_m[rob_walk0_lrd] = rob_walk0_prd;
                if (rob_walk1_valid) spec_m[rob_walk1_lrd] = rob_walk1_prd;
                if (out_ready) ev = '{1'b0, 1'b0};
            end else if (fire) begin
                // Rename lanes one after another: lane 1 naturally sees lane 0's update.
                idx = 0;
                for (int l = 0; l < 2; l++) begin
                    ev[l] = v[l];
                    if (v[l]) begin
                        ep1[l] = spec_m[s1[l]];
                        ep2[l] = spec_m[s2[l]];
                        if (w[l]) begin
                            epd[l] = alloc[idx];
                            idx++;
                            eold[l] = spec_m[d[l]];
                            spec_m[d[l]] = epd[l];
                        end else begin
                            epd[l] = 0;
                            eold[l] = 0;
                        end
                    end
                end
            end else if (out_ready) begin
                ev = '{1'b0, 1'b0};
            end
        end
        @(posedge clock);
        #1;
        chk("out0_valid", out0_valid, ev[0]);
        chk("out1_valid", out1_valid, ev[1]);
        if (ev[0] || was_reset) begin
            chk("out0_prs1", out0_prs1, ep1[0]);
            chk("out0_prs2", out0_prs2, ep2[0]);
            chk("out0_prd", out0_prd, epd[0]);
            chk("out0_old_prd", out0_old_prd, eold[0]);
        end
        if (ev[1] || was_reset) begin
            chk("out1_prs1", out1_prs1, ep1[1]);
            chk("out1_prs2", out1_prs2, ep2[1]);
            chk("out1_prd", out1_prd, epd[1]);
            chk("out1_old_prd", out1_old_prd, eold[1]);
        end
    endtask

    int walk_left = 0;

    initial begin
        clear_inputs();
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset, then one rename of x5.
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrs1 = 3; instr0_lrs2 = 0; instr0_lrd = 5;
        req0_data = 6'd32;
        tick();
        chk("r1_prs1", out0_prs1, 3);
        chk("r1_prs2", out0_prs2, 0);
        chk("r1_prd", out0_prd, 32);
        chk("r1_old", out0_old_prd, 5);
        clear_inputs();
        instr0_valid = 1; instr0_lrs1 = 5;
        tick();
        chk("r1_lookup_x5", out0_prs1, 32);

        // Intra-group bypass on x7.
        clear_inputs();
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 7; req0_data = 6'd40;
        instr1_valid = 1; instr1_need_to_wb = 1; instr1_lrs1 = 7; instr1_lrd = 7; req1_data = 6'd41;
        tick();
        chk("byp_prs1", out1_prs1, 40);
        chk("byp_old", out1_old_prd, 40);
        clear_inputs();
        instr0_valid = 1; instr0_lrs1 = 7;
        tick();
        chk("byp_spec7", out0_prs1, 41);

        // Compacted request: only lane 1 writes.
        clear_inputs();
        instr0_valid = 1; instr0_need_to_wb = 0; instr0_lrd = 4;
        instr1_valid = 1; instr1_need_to_wb = 1; instr1_lrd = 9;
        req0_data = 6'd50; req1_data = 6'd51;
        #1;
        chk("cmp_req0", req0_valid, 1);
        chk("cmp_req1", req1_valid, 0);
        tick();
        chk("cmp_prd1", out1_prd, 50);
        chk("cmp_prd0", out0_prd, 0);

        // Backpressure.
        clear_inputs();
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrs1 = 1; instr0_lrd = 2; req0_data = 6'd20;
        tick();
        out_ready = 0; req0_data = 6'd21; instr0_lrd = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_prd", out0_prd, 20);
        end
        out_ready = 1; free_count = 6'd1;
        instr1_valid = 1; instr1_need_to_wb = 1; instr1_lrd = 4;
        #1;
        chk("bp_free_short", in_ready, 0);
        tick();

        // Rollback then walk.
        clear_inputs();
        reset = 1; tick(); reset = 0;
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 5; req0_data = 6'd32;
        instr1_valid = 1; instr1_need_to_wb = 1; instr1_lrd = 6; req1_data = 6'd33;
        tick();
        clear_inputs();
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 7; req0_data = 6'd35;
        commit0_valid = 1; commit0_lrd = 5; commit0_prd = 6'd32;
        tick();
        clear_inputs();
        rob_state = ROB_STATE_ROLLBACK;
        commit0_valid = 1; commit0_lrd = 6; commit0_prd = 6'd33;
        tick();
        chk("rb_out_valid", out0_valid, 0);
        clear_inputs();
        rob_state = ROB_STATE_WALK;
        rob_walk0_valid = 1; rob_walk0_lrd = 4; rob_walk0_prd = 6'd34;
        #1;
        chk("walk_in_ready", in_ready, 0);
        tick();
        clear_inputs();
        instr0_valid = 1; instr0_lrs1 = 5; instr0_lrs2 = 6;
        instr1_valid = 1; instr1_lrs1 = 4; instr1_lrs2 = 7;
        tick();
        chk("rb_spec5", out0_prs1, 32);
        chk("rb_spec6", out0_prs2, 33);
        chk("walk_spec4", out1_prs1, 34);
        chk("rb_spec7", out1_prs2, 7);

        // Arch reg 0 and reset mid-stream.
        clear_inputs();
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrd = 0; req0_data = 6'd44;
        #1;
        chk("x0_req0", req0_valid, 0);
        tick();
        chk("x0_prd", out0_prd, 0);
        clear_inputs();
        instr0_valid = 1; instr0_need_to_wb = 1; instr0_lrs1 = 0; instr0_lrs2 = 5; instr0_lrd = 3;
        req0_data = 6'd45;
        tick();
        chk("x0_lookup", out0_prs1, 0);
        chk("mid_valid", out0_valid, 1);
        clear_inputs();
        out_ready = 0; reset = 1;
        tick();
        chk("mid_rst_valid", out0_valid, 0);
        chk("mid_rst_prd", out0_prd, 0);
        clear_inputs();
        instr0_valid = 1; instr0_lrs1 = 3; instr0_lrs2 = 5;
        tick();
        chk("mid_rst_x3", out0_prs1, 3);
        chk("mid_rst_x5", out0_prs2, 5);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            if (walk_left > 0) begin
                rob_state = ROB_STATE_WALK;
                walk_left--;
                rob_walk0_valid = 1'($urandom_range(0, 1));
                rob_walk0_lrd = 5'($urandom_range(1, 7));
                rob_walk0_prd = 6'($urandom);
                rob_walk1_valid = 1'($urandom_range(0, 1));
                rob_walk1_lrd = 5'($urandom_range(1, 7));
                rob_walk1_prd = 6'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                rob_state = ROB_STATE_ROLLBACK;
                walk_left = int'($urandom_range(0, 3));
            end
            instr0_valid = 1'($urandom_range(0, 3) != 0);
            instr1_valid = 1'($urandom_range(0, 1));
            instr0_need_to_wb = 1'($urandom_range(0, 3) != 0);
            instr1_need_to_wb = 1'($urandom_range(0, 3) != 0);
            instr0_lrs1 = 5'($urandom_range(0, 7)); instr0_lrs2 = 5'($urandom_range(0, 7));
            instr0_lrd = 5'($urandom_range(0, 7));
            instr1_lrs1 = 5'($urandom_range(0, 7)); instr1_lrs2 = 5'($urandom_range(0, 7));
            instr1_lrd = 5'($urandom_range(0, 7));
            req0_data = 6'($urandom); req1_data = 6'($urandom);
            free_count = 6'($urandom_range(0, 4));
            out_ready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                commit0_valid = 1; commit0_lrd = 5'($urandom_range(0, 7)); commit0_prd = 6'($urandom);
                commit1_valid = 1'($urandom_range(0, 1));
                commit1_lrd = 5'($urandom_range(0, 7)); commit1_prd = 6'($urandom);
            end
            if ($urandom_range(0, 99) == 0) reset = 1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rename_map.md
# rename_map

Speculative and architectural register alias tables for the rename stage: two instructions per cycle. The block sits directly downstream of `freelist`. It consumes the freelist's `req0_data`/`req1_data` as new destination pregs, and drives `req0_valid`/`req1_valid` back to it. It produces renamed source and destination pregs, plus the displaced old preg that the ROB frees at commit. ROB commit keeps the architectural table current; ROB rollback/walk rebuilds the speculative table.

## Interface
Parameters:
- `ARCH_REGS`, 32, number of architectural registers.
- `LOG_ARCH_REGS`, 5, width of a logical register index.
- `PREG_IDX_WIDTH`, 6, width of a physical register index.

Ports:
- `clock`  in  1  single clock; everything is posedge.
- `reset`  in  1  synchronous, active-high.
- `instrN_valid` (N=0,1)  in  1  lane N holds an instruction.
- `instrN_lrs1`, `instrN_lrs2`, `instrN_lrd`  in  LOG_ARCH_REGS  logical sources and destination.
- `instrN_need_to_wb`  in  1  lane N writes `lrd`.
- `in_ready`  out  1  the rename group fires when `in_ready` is 1 and any `instrN_valid` is 1.
- `free_count`  in  LOG_ARCH_REGS+1  freelist available count.
- `req0_valid`, `req1_valid`  out  1  freelist allocation requests.
- `req0_data`, `req1_data`  in  PREG_IDX_WIDTH  pregs returned by the freelist, same cycle.
- `outN_valid`  out  1  registered lane N result valid.
- `outN_prs1`, `outN_prs2`, `outN_prd`, `outN_old_prd`  out  PREG_IDX_WIDTH  renamed operands.
- `out_ready`  in  1  dispatch accepts the output register.
- `commitN_valid`  in  1  commit lane N retires a write.
- `commitN_lrd`  in  LOG_ARCH_REGS  committed logical destination.
- `commitN_prd`  in  PREG_IDX_WIDTH  committed physical destination.
- `rob_state`  in  2  encoded as `ROB_STATE_IDLE`/`ROLLBACK`/`WALK`.
- `rob_walkN_valid`  in  1  walk lane N valid.
- `rob_walkN_lrd`  in  LOG_ARCH_REGS  walk logical destination.
- `rob_walkN_prd`  in  PREG_IDX_WIDTH  walk physical destination.

## Operation
- **Reset.** Both tables map arch i to preg i. All `outN_valid`=0. Every other output register is 0.
- **Write-enable.** `wbN = instrN_valid & instrN_need_to_wb & (instrN_lrd != 0)`. Arch reg 0 is never renamed; it always reads preg 0.
- **in_ready.** `in_ready = is_idle & (~out_valid_any | out_ready) & (free_count >= wb0+wb1)`.
- **Compacted requests.** The first lane with `wb` uses `req0` and the second uses `req1`. So `req0_valid = fire & (wb0|wb1)` and `req1_valid = fire & wb0 & wb1`. With lane 1 only, lane 1 takes `req0_data`.
- **Source lookup.** Sources are read from the speculative table.
- **Lane 1 intra-group bypass.** Lane 1 sources/old_prd take lane 0's new prd when `wb0` is 1 and the lrd matches.
- **Table update.** Fire writes the speculative table at the edge. If both lanes write the same lrd, lane 1 wins.
- **Non-writing lanes.** A lane with `wb`=0 outputs `prd`=0 and `old_prd`=0.
- **Output register.** It loads on fire and holds while `out_ready`=0. `outN_valid` clears when `out_ready` is 1 and no fire occurs.
- **Commit.** Commit writes the architectural table in any rob_state; lane 1 wins on an equal lrd. `commitN_lrd`=0 is ignored.
- **ROLLBACK cycle.**
  - speculative ← architectural, including the same-cycle commit writes (forwarded).
  - `outN_valid` ← 0.
  - `in_ready`=0.
- **WALK.**
  - Each valid walk lane writes spec[lrd] ← prd, in lane order; lane 1 wins.
  - No fire occurs and `outN_valid` stays 0.
- **IDLE.** Normal rename operation.

## Timing
- Table lookup and freelist data are combinational in the fire cycle. Results appear on `outN_*` one cycle after fire.
- A table write at edge k is visible to a group firing in cycle k+1, with no bubble.
- Walk writes at edge k are visible to lookups from cycle k+1. The first fire after WALK→IDLE sees all walk writes.
- Rollback overrides any pending output in the same cycle.
- Reset asserted mid-operation restores the reset mapping at the next edge and discards outputs.

## Structure
- Shared package/defines hold the `ROB_STATE_IDLE`, `ROB_STATE_ROLLBACK`, `ROB_STATE_WALK` encodings and the `WALK_SIZE`=2 constant, reused from the ROB/freelist.
- Sub-module `rat_regfile`:
  - ARCH_REGS×PREG_IDX_WIDTH.
  - Four read ports, plus two old-prd read ports.
  - Two ordered write ports.
  - Bulk-load input.
  - It is instantiated twice: speculative (bulk-load used on rollback) and architectural (read only by the bulk path).

## Test plan
- **Reset, then one rename.** Reset, then lane 0 renames lrs1=3, lrs2=0, lrd=5 with `req0_data`=32. Expected: `out0_prs1`=3, `prs2`=0, `prd`=32, `old_prd`=5. The next lookup of x5 returns 32.
- **Intra-group bypass.** Lane 0 renames lrd=7 (`req0_data`=40). Lane 1 renames lrs1=7, lrd=7 (`req1_data`=41). Expected: lane 1 `prs1`=40, `old_prd`=40. spec[7]=41.
- **Compacted request.**
  - Stimulus: lane 0 `need_to_wb`=0, lane 1 lrd=9.
  - Expected requests: `req0_valid`=1, `req1_valid`=0.
  - Expected lane 1 result: `prd`=`req0_data`.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles. Expected: outputs stable and `in_ready`=0. When `free_count`=1 and both lanes write, `in_ready`=0.
- **Rollback then walk.**
  - Rename x5→32 and x6→33, then commit x5→32.
  - ROLLBACK, same cycle commit x6→33. Expected: spec[5]=32, spec[6]=33.
  - WALK with x4→34. Expected: spec[4]=34.
- **Arch reg 0 and reset mid-stream.** A lane with lrd=0 requests nothing and leaves preg 0 mapped. Reset asserted with `outN_valid`=1 clears outputs and restores identity.
